// File: rtl/posterior_state_serial_pkg.sv
// ============================================================================
// Module : posterior_state_serial_pkg
// Desc   : Shared fixed-point widths and sequencer states for the posterior stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package posterior_state_serial_pkg;

    localparam int FXP_N    = 16;
    localparam int FXP_FRAC = 8;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_HX0  = 4'd1,
        ST_HX1  = 4'd2,
        ST_Y0   = 4'd3,
        ST_Y1   = 4'd4,
        ST_KLD  = 4'd5,
        ST_KX0  = 4'd6,
        ST_KX1  = 4'd7,
        ST_X0   = 4'd8,
        ST_X1   = 4'd9
    } state_t;

endpackage

`default_nettype wire

// File: rtl/posterior_state_serial_align_sat.sv
// ============================================================================
// Module : posterior_state_serial_align_sat
// Desc   : 2N -> N fixed-point realignment (floor); saturates when
//          KF_POST_SAT_EN is defined, otherwise wraps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module posterior_state_serial_align_sat #(
    parameter int N    = 16,
    parameter int FRAC = 8
) (
    input  logic [2*N-1:0] i_din,
    output logic [N-1:0]   o_dout,
    output logic           o_sat
);

    logic [N-1:0] w_slice;

    assign w_slice = i_din[FRAC+N-1:FRAC];

`ifdef KF_POST_SAT_EN
    logic [N-FRAC:0] w_hi;
    logic            w_ovf;
    logic            w_unused;

    // Bits above the kept slice must all match its sign bit to be representable.
    assign w_hi     = i_din[2*N-1:FRAC+N-1];
    assign w_ovf    = !((&w_hi) || !(|w_hi));
    assign w_unused = ^i_din[FRAC-1:0];

    always_comb begin
        o_dout = w_slice;
        if (w_ovf) begin
            o_dout = i_din[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

    assign o_sat = w_ovf;
`else
    logic w_unused;

    assign w_unused = ^{i_din[2*N-1:FRAC+N], i_din[FRAC-1:0]};
    assign o_dout   = w_slice;
    assign o_sat    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/posterior_state_serial.sv
// ============================================================================
// Module : posterior_state_serial
// Desc   : Serial Kalman measurement update X_POST = x + K*(z - H*x) using two
//          multipliers and one shared adder; KF_POST_SAT_EN enables saturation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module posterior_state_serial
    import posterior_state_serial_pkg::*;
#(
    parameter int N    = FXP_N,
    parameter int FRAC = FXP_FRAC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x00,
    input  logic [N-1:0] x10,
    input  logic [N-1:0] z00,
    input  logic [N-1:0] z10,
    input  logic [N-1:0] h00,
    input  logic [N-1:0] h01,
    input  logic [N-1:0] h10,
    input  logic [N-1:0] h11,
    input  logic [N-1:0] k00,
    input  logic [N-1:0] k01,
    input  logic [N-1:0] k10,
    input  logic [N-1:0] k11,
    output logic         busy,
    output logic         done,
    output logic         sat_flag,
    output logic [N-1:0] X_POST00,
    output logic [N-1:0] X_POST10
);

    state_t r_st, w_st_nxt;

    logic [N-1:0]   r_x0, r_x1, r_z0, r_z1;
    logic [N-1:0]   r_h00, r_h01, r_h10, r_h11;
    logic [N-1:0]   r_k00, r_k01, r_k10, r_k11;
    logic [N-1:0]   r_ma0, r_mb0, r_ma1, r_mb1;
    logic [2*N-1:0] r_hx0, r_hx1, r_kx0, r_kx1;
    logic [N-1:0]   r_y0, r_y1;
    logic [N-1:0]   r_post0, r_post1;
    logic           r_done, r_sat;

    logic           w_accept;
    logic [2*N-1:0] w_p0, w_p1;
    logic [2*N-1:0] w_add_a, w_add_b;
    logic           w_sub;
    logic [2*N:0]   w_sum_ext;
    logic [2*N-1:0] w_sum;
    logic [N-1:0]   w_aligned;
    logic           w_align_sat;
    logic           w_unused_msb;

    // Lift an N-bit value with FRAC fraction bits to the 2*FRAC product scale.
    function automatic logic [2*N-1:0] f_scale(input logic [N-1:0] v);
        return {{(N-FRAC){v[N-1]}}, v, {FRAC{1'b0}}};
    endfunction

    assign w_p0 = $signed({{N{r_ma0[N-1]}}, r_ma0}) * $signed({{N{r_mb0[N-1]}}, r_mb0});
    assign w_p1 = $signed({{N{r_ma1[N-1]}}, r_ma1}) * $signed({{N{r_mb1[N-1]}}, r_mb1});

    assign w_sum_ext = {w_add_a[2*N-1], w_add_a}
                     + ({w_add_b[2*N-1], w_add_b} ^ {(2*N+1){w_sub}})
                     + {{(2*N){1'b0}}, w_sub};
    assign w_sum        = w_sum_ext[2*N-1:0];
    assign w_unused_msb = w_sum_ext[2*N];

    posterior_state_serial_align_sat #(
        .N    (N),
        .FRAC (FRAC)
    ) u_align (
        .i_din  (w_sum),
        .o_dout (w_aligned),
        .o_sat  (w_align_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st <= ST_IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_comb begin
        w_st_nxt = r_st;
        w_accept = 1'b0;
        w_add_a  = w_p0;
        w_add_b  = w_p1;
        w_sub    = 1'b0;
        case (r_st)
            // The done cycle is still part of the job, so no start is taken then.
            ST_IDLE: begin
                if (start && !r_done) begin
                    w_accept = 1'b1;
                    w_st_nxt = ST_HX0;
                end
            end
            ST_HX0: w_st_nxt = ST_HX1;
            ST_HX1: w_st_nxt = ST_Y0;
            ST_Y0: begin
                w_add_a  = f_scale(r_z0);
                w_add_b  = r_hx0;
                w_sub    = 1'b1;
                w_st_nxt = ST_Y1;
            end
            ST_Y1: begin
                w_add_a  = f_scale(r_z1);
                w_add_b  = r_hx1;
                w_sub    = 1'b1;
                w_st_nxt = ST_KLD;
            end
            ST_KLD: w_st_nxt = ST_KX0;
            ST_KX0: w_st_nxt = ST_KX1;
            ST_KX1: w_st_nxt = ST_X0;
            ST_X0: begin
                w_add_a  = f_scale(r_x0);
                w_add_b  = r_kx0;
                w_st_nxt = ST_X1;
            end
            ST_X1: begin
                w_add_a  = f_scale(r_x1);
                w_add_b  = r_kx1;
                w_st_nxt = ST_IDLE;
            end
            default: w_st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0    <= '0;
            r_x1    <= '0;
            r_z0    <= '0;
            r_z1    <= '0;
            r_h00   <= '0;
            r_h01   <= '0;
            r_h10   <= '0;
            r_h11   <= '0;
            r_k00   <= '0;
            r_k01   <= '0;
            r_k10   <= '0;
            r_k11   <= '0;
            r_ma0   <= '0;
            r_mb0   <= '0;
            r_ma1   <= '0;
            r_mb1   <= '0;
            r_hx0   <= '0;
            r_hx1   <= '0;
            r_kx0   <= '0;
            r_kx1   <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_post0 <= '0;
            r_post1 <= '0;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_done <= (r_st == ST_X1);
            case (r_st)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x0  <= x00;
                        r_x1  <= x10;
                        r_z0  <= z00;
                        r_z1  <= z10;
                        r_h00 <= h00;
                        r_h01 <= h01;
                        r_h10 <= h10;
                        r_h11 <= h11;
                        r_k00 <= k00;
                        r_k01 <= k01;
                        r_k10 <= k10;
                        r_k11 <= k11;
                        r_ma0 <= h00;
                        r_mb0 <= x00;
                        r_ma1 <= h01;
                        r_mb1 <= x10;
                        r_sat <= 1'b0;
                    end
                end
                ST_HX0: begin
                    r_hx0 <= w_sum;
                    r_ma0 <= r_h10;
                    r_mb0 <= r_x0;
                    r_ma1 <= r_h11;
                    r_mb1 <= r_x1;
                end
                ST_HX1: r_hx1 <= w_sum;
                ST_Y0: begin
                    r_y0  <= w_aligned;
                    r_sat <= r_sat | w_align_sat;
                end
                ST_Y1: begin
                    r_y1  <= w_aligned;
                    r_sat <= r_sat | w_align_sat;
                end
                ST_KLD: begin
                    r_ma0 <= r_k00;
                    r_mb0 <= r_y0;
                    r_ma1 <= r_k01;
                    r_mb1 <= r_y1;
                end
                ST_KX0: begin
                    r_kx0 <= w_sum;
                    r_ma0 <= r_k10;
                    r_mb0 <= r_y0;
                    r_ma1 <= r_k11;
                    r_mb1 <= r_y1;
                end
                ST_KX1: begin
                    r_kx1 <= w_sum;
                    r_ma0 <= '0;
                    r_mb0 <= '0;
                    r_ma1 <= '0;
                    r_mb1 <= '0;
                end
                ST_X0: begin
                    r_post0 <= w_aligned;
                    r_sat   <= r_sat | w_align_sat;
                end
                ST_X1: begin
                    r_post1 <= w_aligned;
                    r_sat   <= r_sat | w_align_sat;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_st != ST_IDLE) || r_done;
    assign done     = r_done;
    assign sat_flag = r_sat;
    assign X_POST00 = r_post0;
    assign X_POST10 = r_post1;

endmodule

`default_nettype wire

// File: tb/tb_posterior_state_serial.sv
// ============================================================================
// Module : tb_posterior_state_serial
// Desc   : Self-checking bench for posterior_state_serial (N=16, FRAC=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_posterior_state_serial;

    localparam int N    = 16;
    localparam int FRAC = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] x00 = '0, x10 = '0, z00 = '0, z10 = '0;
    logic [N-1:0] h00 = '0, h01 = '0, h10 = '0, h11 = '0;
    logic [N-1:0] k00 = '0, k01 = '0, k10 = '0, k11 = '0;
    logic         busy, done, sat_flag;
    logic [N-1:0] X_POST00, X_POST10;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    posterior_state_serial dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x00      (x00),
        .x10      (x10),
        .z00      (z00),
        .z10      (z10),
        .h00      (h00),
        .h01      (h01),
        .h10      (h10),
        .h11      (h11),
        .k00      (k00),
        .k01      (k01),
        .k10      (k10),
        .k11      (k11),
        .busy     (busy),
        .done     (done),
        .sat_flag (sat_flag),
        .X_POST00 (X_POST00),
        .X_POST10 (X_POST10)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint sx(input logic [N-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint wrap2n(input longint v);
        int t;
        t = int'(v);
        return longint'(t);
    endfunction

    function automatic logic [N-1:0] align_m(input longint v, inout bit s);
        longint q;
        q = wrap2n(v) >>> FRAC;
`ifdef KF_POST_SAT_EN
        if (q > 32767) begin q = 32767; s = 1'b1; end
        else if (q < -32768) begin q = -32768; s = 1'b1; end
`endif
        return q[N-1:0];
    endfunction

    task automatic model_job(output logic [N-1:0] p0, output logic [N-1:0] p1, output bit s);
        longint xv[2], zv[2], hm[2][2], km[2][2], yv[2], hx, kx;
        logic [N-1:0] y[2], p[2];
        s = 1'b0;
        xv[0] = sx(x00); xv[1] = sx(x10);
        zv[0] = sx(z00); zv[1] = sx(z10);
        hm[0][0] = sx(h00); hm[0][1] = sx(h01); hm[1][0] = sx(h10); hm[1][1] = sx(h11);
        km[0][0] = sx(k00); km[0][1] = sx(k01); km[1][0] = sx(k10); km[1][1] = sx(k11);
        for (int i = 0; i < 2; i++) begin
            hx    = wrap2n(hm[i][0] * xv[0] + hm[i][1] * xv[1]);
            y[i]  = align_m(zv[i] * (1 << FRAC) - hx, s);
            yv[i] = sx(y[i]);
        end
        for (int i = 0; i < 2; i++) begin
            kx   = wrap2n(km[i][0] * yv[0] + km[i][1] * yv[1]);
            p[i] = align_m(xv[i] * (1 << FRAC) + kx, s);
        end
        p0 = p[0];
        p1 = p[1];
    endtask

    // cnt = cycles of the current job still to come, the last one being the done cycle
    int           cnt = 0;
    logic [N-1:0] e0 = '0, e1 = '0, n0 = '0, n1 = '0;
    bit           esat = 1'b0, nsat = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            cnt = 0; e0 = '0; e1 = '0; esat = 1'b0;
        end else if (cnt == 0) begin
            if (start) begin
                model_job(n0, n1, nsat);
                cnt = 10;
            end
        end else begin
            cnt--;
            if (cnt == 2) e0 = n0;
            if (cnt == 1) begin e1 = n1; esat = nsat; end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, cnt != 0);
        chk("done", done, cnt == 1);
        chk("X_POST00", X_POST00, e0);
        chk("X_POST10", X_POST10, e1);
        if (cnt <= 1) chk("sat_flag", sat_flag, esat);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_job(input logic [N-1:0] a00, a01, a10, a11,
                           input logic [N-1:0] g00, g01, g10, g11,
                           input logic [N-1:0] xa, xb, za, zb);
        h00 = a00; h01 = a01; h10 = a10; h11 = a11;
        k00 = g00; k01 = g01; k10 = g10; k11 = g11;
        x00 = xa; x10 = xb; z00 = za; z10 = zb;
    endtask

    task automatic scramble();
        {h00, h01, h10, h11} = {$urandom, $urandom};
        {k00, k01, k10, k11} = {$urandom, $urandom};
        {x00, x10, z00, z10} = {$urandom, $urandom};
    endtask

    // Launch a job, then wait (bounded) for done; ends at the done-cycle negedge.
    task automatic run_job(output int lat, output int busy_cnt);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        scramble();
        lat = 0;
        busy_cnt = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (done) break;
        end
    endtask

    int lat, bcnt;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_x00", X_POST00, 0);

        // 1: H=I, K=0
        set_job(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0,
                16'h0100, 16'h0200, 16'h0500, 16'h0500);
        run_job(lat, bcnt);
        chk("t1_latency", lat, 10);
        chk("t1_busy_cycles", bcnt, 10);
        chk("t1_x00", X_POST00, 16'h0100);
        chk("t1_x10", X_POST10, 16'h0200);

        // 2: H=I, K=0.5I (back-to-back with previous done)
        set_job(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0080, 16'h0, 16'h0, 16'h0080,
                16'h0100, 16'h0200, 16'h0300, 16'h0000);
        run_job(lat, bcnt);
        chk("t2_latency", lat, 10);
        chk("t2_x00", X_POST00, 16'h0200);
        chk("t2_x10", X_POST10, 16'h0100);

        // 3: full matrices
        set_job(16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0080, 16'h0000, 16'h0040, 16'h0080,
                16'h0100, 16'h0100, 16'h0300, 16'h0200);
        run_job(lat, bcnt);
        chk("t3_x00", X_POST00, 16'h0180);
        chk("t3_x10", X_POST10, 16'h01C0);

        // 4a: start held high through the whole job
        set_job(16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0080, 16'h0000, 16'h0040, 16'h0080,
                16'h0100, 16'h0100, 16'h0300, 16'h0200);
        @(posedge clk); #1 start = 1'b1;
        repeat (10) @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("t4_held_done", done, 1);
        chk("t4_held_x10", X_POST10, 16'h01C0);
        // 4b: restart right after done, stray start pulses in states 3 and 7
        set_job(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0080, 16'h0, 16'h0, 16'h0080,
                16'h0100, 16'h0200, 16'h0300, 16'h0000);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        chk("t4_restart_done", done, 1);
        chk("t4_restart_x00", X_POST00, 16'h0200);
        chk("t4_restart_x10", X_POST10, 16'h0100);

        // 5: reset while in state 6, then a fresh job
        set_job(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0080, 16'h0, 16'h0, 16'h0080,
                16'h0100, 16'h0200, 16'h0300, 16'h0000);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_x00", X_POST00, 0);
        chk("t5_x10", X_POST10, 0);
        repeat (15) @(negedge clk);
        set_job(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0080, 16'h0, 16'h0, 16'h0080,
                16'h0100, 16'h0200, 16'h0300, 16'h0000);
        run_job(lat, bcnt);
        chk("t5_fresh_x00", X_POST00, 16'h0200);
        chk("t5_fresh_x10", X_POST10, 16'h0100);

        // 6: positive overflow of the final realignment
        set_job(16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0100,
                16'h7F00, 16'h0000, 16'h7F00, 16'h0000);
        run_job(lat, bcnt);
`ifdef KF_POST_SAT_EN
        chk("t6_x00", X_POST00, 16'h7FFF);
        chk("t6_sat", sat_flag, 1);
`else
        chk("t6_x00", X_POST00, 16'hFE00);
        chk("t6_sat", sat_flag, 0);
`endif

        // negative overflow, then mixed-sign vectors (model-checked only)
        set_job(16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0100,
                16'h8100, 16'h0000, 16'h8100, 16'h0000);
        run_job(lat, bcnt);
        set_job(16'h0180, 16'hFF40, 16'h0020, 16'hFFFF, 16'h0040, 16'hFFC0, 16'h00C0, 16'h0010,
                16'hFE80, 16'h0333, 16'h0100, 16'hF800);
        run_job(lat, bcnt);
        chk("t7_latency", lat, 10);
        set_job(16'hFF00, 16'h0280, 16'h8000, 16'h0101, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h0200,
                16'h1234, 16'hEDCB, 16'h8000, 16'h7FFF);
        run_job(lat, bcnt);
        chk("t8_latency", lat, 10);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
